// File: rtl/led_bank_ctrl.sv
// -----------------------------------------------------------------------------
// led_bank_ctrl
//   Multi-channel LED driver controlled by a byte-command stream. Each channel
//   is independently OFF, ON, BLINK (one shared toggle rate, all blinking
//   channels in phase) or PWM (per-channel duty against one shared counter).
//
//   Command protocol:
//     header byte : [7:6] mode (00 OFF, 01 ON, 10 BLINK, 11 PWM), [5:0] channel
//     PWM header  : followed by one argument byte, low PWM_BITS = duty
//   A command naming a channel >= CHANNELS changes nothing and raises a
//   one-cycle cmd_err after its final byte.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   synchronous reset, active low
//   s_axis_tdata   in   command byte
//   s_axis_tvalid  in   command byte valid
//   s_axis_tready  out  command byte ready (high every cycle out of reset)
//   led            out  LED drive per channel, 1 = lit, registered
//   cmd_err        out  one-cycle pulse on a command for a missing channel
// -----------------------------------------------------------------------------
module led_bank_ctrl #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BLINK_HZ  = 1,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned PWM_BITS  = 8,
   parameter int unsigned HEARTBEAT = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   output logic [CHANNELS-1:0] led,
   output logic                cmd_err
);

   // Blink half period in clock cycles; the counter runs 0..HALF-1.
   localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned BCW  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BCW-1:0] HALF_M1 = BCW'(HALF - 1);

   // Channel limit widened by one bit so CHANNELS = 64 is representable.
   localparam logic [6:0] CHAN_LIM = 7'(CHANNELS);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_PWM   = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ARG  = 1'b1;

   // ---------------------------------------------------------------------
   // Shared state
   // ---------------------------------------------------------------------
   logic                tready_q;
   logic [0:0]          state_q,     state_d;
   logic [5:0]          chan_q,      chan_d;
   logic                err_q,       err_d;
   logic [BCW-1:0]      blink_cnt_q, blink_cnt_d;
   logic                phase_q,     phase_d;
   logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;

   // Command decode results, valid for the current cycle only.
   logic                accept;
   logic                commit;
   logic                commit_duty;
   logic [1:0]          commit_mode;
   logic [5:0]          commit_chan;
   logic                chan_ok;

   assign accept        = s_axis_tvalid & tready_q;
   assign s_axis_tready = tready_q;
   assign cmd_err       = err_q;

   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      commit      = 1'b0;
      commit_duty = 1'b0;
      commit_mode = s_axis_tdata[7:6];
      commit_chan = s_axis_tdata[5:0];

      if (accept) begin
         if (state_q == ST_IDLE) begin
            if (s_axis_tdata[7:6] == MODE_PWM) begin
               // Channel validity is judged only once the argument arrives,
               // so a bad PWM header still swallows its argument byte.
               state_d = ST_ARG;
               chan_d  = s_axis_tdata[5:0];
            end else begin
               commit = 1'b1;
            end
         end else begin
            commit      = 1'b1;
            commit_duty = 1'b1;
            commit_mode = MODE_PWM;
            commit_chan = chan_q;
            state_d     = ST_IDLE;
         end
      end
   end

   assign chan_ok = ({1'b0, commit_chan} < CHAN_LIM);
   assign err_d   = commit & ~chan_ok;

   // Free-running timebases: never restarted by commands, so a channel
   // switched into BLINK joins the existing phase.
   always_comb begin
      phase_d = phase_q;
      if (blink_cnt_q == HALF_M1) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
      pwm_cnt_d = pwm_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tready_q    <= 1'b0;
         state_q     <= ST_IDLE;
         chan_q      <= '0;
         err_q       <= 1'b0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         pwm_cnt_q   <= '0;
      end else begin
         tready_q    <= 1'b1;
         state_q     <= state_d;
         chan_q      <= chan_d;
         err_q       <= err_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         pwm_cnt_q   <= pwm_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Per-channel mode/duty registers and output stage
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         localparam logic [1:0] RST_MODE =
            (gi == 0 && HEARTBEAT != 0) ? MODE_BLINK : MODE_OFF;

         logic [1:0]          mode_q;
         logic [PWM_BITS-1:0] duty_q;
         logic                led_q;
         logic                led_d;
         logic                hit;

         assign hit = commit & chan_ok & (commit_chan == 6'(gi));

         // Output uses the registered mode, giving one cycle from the
         // committing handshake to the visible LED change.
         always_comb begin
            case (mode_q)
               MODE_ON:    led_d = 1'b1;
               MODE_BLINK: led_d = phase_q;
               MODE_PWM:   led_d = (pwm_cnt_q < duty_q);
               default:    led_d = 1'b0;
            endcase
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               mode_q <= RST_MODE;
               duty_q <= '0;
               led_q  <= 1'b0;
            end else begin
               if (hit) begin
                  mode_q <= commit_mode;
                  // Duty is kept when a channel leaves PWM.
                  if (commit_duty) begin
                     duty_q <= s_axis_tdata[PWM_BITS-1:0];
                  end
               end
               led_q <= led_d;
            end
         end

         assign led[gi] = led_q;
      end
   endgenerate

endmodule
